// File: rtl/data_mem_pkg.sv
// data_mem_pkg: MMIO register map and trace entry width shared by data_mem_resp
// and its trace FIFO.
package data_mem_pkg;

   localparam logic [5:0] CYCLES_OFS  = 6'h00;
   localparam logic [5:0] STORES_OFS  = 6'h04;
   localparam logic [5:0] TCOUNT_OFS  = 6'h08;
   localparam logic [5:0] SCRATCH_OFS = 6'h0C;
   localparam logic [5:0] CTRL_OFS    = 6'h10;

   localparam int CTRL_CLR_BIT = 0;

   // One trace entry is {byte address, store data}.
   localparam int TRACE_W = 64;

endpackage

// File: rtl/data_mem_resp_trace_fifo.sv
// trace_fifo: synchronous pointer-based FIFO with an extra wrap bit per pointer,
// combinational head output and push-while-full allowed when a pop coincides.
module trace_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic                     valid,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   always_comb begin
      valid     = wr_ptr_q != rd_ptr_q;
      full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      count     = wr_ptr_q - rd_ptr_q;
      do_pop    = pop && valid;
      do_push   = push && (!full || do_pop);
      wr_ptr_d  = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, do_pop};
      head_data = valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: data-memory responder serving word RAM and a status block.
// The store trace FIFO and its port exist only when DATA_MEM_TRACE_EN is defined.
module data_mem_resp #(
   parameter int unsigned MEM_WORDS   = 1024,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
   parameter int unsigned TRACE_DEPTH = 8
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] DataMemAddr,
   input  logic        DataMemRead,
   input  logic        DataMemWrite,
   input  logic [31:0] DataMemWData,
   output logic [31:0] DataMemRData,
   output logic        TraceValid,
   input  logic        TraceReady,
   output logic [31:0] TraceAddr,
   output logic [31:0] TraceData,
   output logic        TraceOverflow,
   output logic        ErrAddr
);

   import data_mem_pkg::*;

   localparam int          IDX_W     = $clog2(MEM_WORDS);
   localparam logic [31:0] RAM_BYTES = MEM_WORDS * 4;

   logic [31:0]      ram_mem [MEM_WORDS];
   logic [31:0]      cycles_q, cycles_d;
   logic [31:0]      stores_q, stores_d;
   logic [31:0]      scratch_q, scratch_d;
   logic             ovf_q, ovf_d;
   logic             err_q, err_d;
   logic             aligned, in_ram, in_mmio, access;
   logic             ram_we, mmio_we, ctrl_clr;
   logic [5:0]       ofs;
   logic [IDX_W-1:0] ram_idx;
   logic [31:0]      trace_count;
   logic             trace_drop;

`ifdef DATA_MEM_TRACE_EN
   logic [TRACE_W-1:0]             trace_head;
   logic [$clog2(TRACE_DEPTH):0]   fifo_count;
   logic                           fifo_valid;
   logic                           fifo_full;

   trace_fifo #(
      .DEPTH (TRACE_DEPTH),
      .WIDTH (TRACE_W)
   ) u_trace_fifo (
      .clk       (CLK),
      .rst       (RST),
      .push      (ram_we),
      .push_data ({DataMemAddr, DataMemWData}),
      .pop       (TraceReady),
      .head_data (trace_head),
      .valid     (fifo_valid),
      .full      (fifo_full),
      .count     (fifo_count)
   );

   assign TraceValid  = fifo_valid;
   assign TraceAddr   = trace_head[63:32];
   assign TraceData   = trace_head[31:0];
   assign trace_count = 32'(fifo_count);
   // A full FIFO only accepts the store when the head leaves on the same edge.
   assign trace_drop  = ram_we && fifo_full && !TraceReady;
`else
   logic unused_trace_ready;

   assign unused_trace_ready = TraceReady;
   assign TraceValid  = 1'b0;
   assign TraceAddr   = '0;
   assign TraceData   = '0;
   assign trace_count = '0;
   assign trace_drop  = 1'b0;
`endif

   assign TraceOverflow = ovf_q;
   assign ErrAddr       = err_q;

   always_comb begin
      aligned  = DataMemAddr[1:0] == 2'b00;
      in_ram   = DataMemAddr < RAM_BYTES;
      in_mmio  = DataMemAddr[31:6] == MMIO_BASE[31:6];
      ofs      = DataMemAddr[5:0];
      ram_idx  = DataMemAddr[IDX_W+1:2];
      access   = DataMemRead || DataMemWrite;
      ram_we   = DataMemWrite && aligned && in_ram && !RST;
      mmio_we  = DataMemWrite && aligned && in_mmio;
      ctrl_clr = mmio_we && (ofs == CTRL_OFS) && DataMemWData[CTRL_CLR_BIT];

      DataMemRData = '0;
      if (DataMemRead && aligned) begin
         if (in_ram) begin
            DataMemRData = ram_mem[ram_idx];
         end else if (in_mmio) begin
            case (ofs)
               CYCLES_OFS:  DataMemRData = cycles_q;
               STORES_OFS:  DataMemRData = stores_q;
               TCOUNT_OFS:  DataMemRData = trace_count;
               SCRATCH_OFS: DataMemRData = scratch_q;
               default:     DataMemRData = '0;
            endcase
         end
      end

      cycles_d  = ctrl_clr ? '0 : cycles_q + 32'd1;
      stores_d  = ctrl_clr ? '0 : stores_q + {31'b0, ram_we};
      scratch_d = (mmio_we && ofs == SCRATCH_OFS) ? DataMemWData : scratch_q;
      ovf_d     = !ctrl_clr && (ovf_q || trace_drop);
      err_d     = !ctrl_clr && (err_q || (access && (!aligned || !(in_ram || in_mmio))));
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cycles_q  <= '0;
         stores_q  <= '0;
         scratch_q <= '0;
         ovf_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         cycles_q  <= cycles_d;
         stores_q  <= stores_d;
         scratch_q <= scratch_d;
         ovf_q     <= ovf_d;
         err_q     <= err_d;
      end
   end

   // RAM contents deliberately survive reset.
   always_ff @(posedge CLK) begin
      if (ram_we) begin
         ram_mem[ram_idx] <= DataMemWData;
      end
   end

endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Responder end of the processor's data-memory port: accepts the core's combinational load/store requests and serves them from a word RAM or a small memory-mapped status block. Every RAM store is also captured as an address/data pair in a trace FIFO, drained by the testbench over a valid/ready port. It sits between `RISCV` and the bench and replaces the bench-side behavioural data-memory array.

## Interface
- `MEM_WORDS`, 1024: RAM depth in 32-bit words; power of two.
- `MMIO_BASE`, 32'hFFFF_0000: byte base address of the status block; 64-byte window.
- `TRACE_DEPTH`, 8: trace FIFO entries; power of two, at least 2.
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `DataMemAddr` in 32: byte address from the core.
- `DataMemRead` in 1: load strobe.
- `DataMemWrite` in 1: store strobe.
- `DataMemWData` in 32: store data.
- `DataMemRData` out 32: load data, combinational.
- `TraceValid` out 1: head FIFO entry is valid.
- `TraceReady` in 1: bench accepts the head entry.
- `TraceAddr` out 32: byte address of the head store.
- `TraceData` out 32: data of the head store.
- `TraceOverflow` out 1: sticky; a store was dropped because the FIFO was full.
- `ErrAddr` out 1: sticky; a misaligned or unmapped access was seen.

## Operation
- Decode:
  - RAM when `DataMemAddr < MEM_WORDS*4`; RAM word index is `DataMemAddr[..:2]`.
  - MMIO when the address falls in `MMIO_BASE` to `MMIO_BASE+0x3F`.
  - Any other address is unmapped.
- `DataMemAddr[1:0] != 0` with either strobe set: the access is ignored, reads return 0, and `ErrAddr` is set.
- Unmapped access: reads return 0, writes are dropped, `ErrAddr` is set.
- `DataMemRData` is 0 whenever `DataMemRead` is 0.
- MMIO registers, by offset:
  - +0x00 `CYCLES` (RO): cycles since reset; wraps at 2^32.
  - +0x04 `STORES` (RO): count of accepted RAM writes; wraps.
  - +0x08 `TCOUNT` (RO): current trace FIFO occupancy.
  - +0x0C `SCRATCH` (RW).
  - +0x10 `CTRL` (WO): writing bit0=1 clears `CYCLES`, `STORES`, `TraceOverflow` and `ErrAddr`. Reads of `CTRL` return 0.
- Writes to RO registers are ignored and are not errors.
- RAM write: on the rising edge with `DataMemWrite=1`. `STORES` increments and a {addr, data} entry is pushed to the trace FIFO.
- MMIO writes are not traced.
- FIFO full on push:
  - If `TraceValid && TraceReady` in the same cycle, the pop and the push both occur.
  - Otherwise the entry is dropped and `TraceOverflow` is set.
- Pop happens on a rising edge with `TraceValid && TraceReady`. `TraceAddr`/`TraceData` reflect the head entry combinationally and are 0 when the FIFO is empty.
- Read and write in the same cycle to the same RAM word: the read returns the old value.
- A `CTRL` clear coinciding with a RAM store: the clear wins for `STORES` (result 0). The store itself and its trace push still occur.

## Timing
- Reset values: `CYCLES`=0, `STORES`=0, `SCRATCH`=0, FIFO empty, `TraceValid`=0, `TraceOverflow`=0, `ErrAddr`=0, `TraceAddr`/`TraceData`=0.
- RAM contents are not reset and are preserved across `RST`.
- A reset asserted mid-operation flushes the FIFO and drops any store in that cycle.
- Load latency is 0: combinational from address and strobe.
- A store is visible to a load in the next cycle.
- `TraceValid` rises the cycle after the first push into an empty FIFO.
- `CYCLES` reads 0 in the first cycle after `RST` deasserts and increments every cycle thereafter.

## Configuration
- `DATA_MEM_TRACE_EN` defined: trace FIFO and trace port are present as described.
- Not defined:
  - No FIFO storage is built.
  - `TraceValid`, `TraceAddr`, `TraceData` and `TraceOverflow` are tied to 0.
  - `TCOUNT` reads 0.
  - `STORES`, `ErrAddr` and all RAM behaviour are unchanged.

## Structure
- Package `data_mem_pkg` holds the MMIO offset constants (`CYCLES_OFS` … `CTRL_OFS`), the `CTRL` clear-bit index, and the trace entry width (64).
- Sub-module `trace_fifo`: parameterised synchronous FIFO. Pointer-based, one extra pointer bit for full/empty, combinational head output, simultaneous push/pop supported when full.

## Test plan
- Reset, then store 0x11 to addr 0x0, 0x22 to 0x10, 0x33 to 0x20, 0x44 to 0x30 → loads return 0x11/0x22/0x33/0x44; `STORES`=4; trace pops give (0x0,0x11) … (0x30,0x44) in order.
- Hold `TraceReady`=0 and issue 9 stores with `TRACE_DEPTH`=8 → `TCOUNT`=8, `TraceOverflow`=1, first pop is the first store.
- FIFO full, store with `TraceReady`=1 in the same cycle → no overflow, `TCOUNT` stays 8.
- Load from 0x2 and store to 0x0000_1000 (`MEM_WORDS`=1024) → `RData`=0, `ErrAddr`=1, RAM unchanged.
- Run 20 idle cycles after reset, then read `CYCLES` → 20. Write 1 to `CTRL`; on the next cycle `CYCLES` reads 0 and `STORES` reads 0.
- Store 0xABCD to addr 0x8, assert `RST` for 1 cycle, then load from 0x8 → 0xABCD, `TraceValid`=0, `STORES`=0.
